lora_tx: RTL and testbench

UART frame transmitter feeding the LoRa module's RX pin. On a one-cycle `send` request it latches a 4-byte payload and shifts it out serially, MSB byte first, each byte as an 8N1 character (LSB bit first) at `BAUD_DIV` clocks per bit. It is the transmit-side counterpart of `lora_rx` on the home board. It sits between the board's event/keypad logic and the LoRa UART.

---
 rtl/lora_pkg.sv | 20 ++
 rtl/lora_tx_if.sv | 17 +
 rtl/uart_byte_tx.sv | 112 +++++++++++
 rtl/lora_tx.sv | 81 ++++++++
 tb/tb_lora_tx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/lora_pkg.sv
// Shared LoRa UART definitions used by lora_tx and lora_rx.
// Build option LORA_TX_PARITY_EN adds an even-parity bit per character (8E1).
package lora_pkg;

  localparam int unsigned CLK_FREQ_HZ    = 50_000_000;
  localparam int unsigned BAUD_DIV_DFLT  = 434;
  localparam int unsigned NUM_BYTES_DFLT = 4;
  localparam int unsigned BITS_PER_BYTE  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef LORA_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/lora_tx_if.sv
// Request/serial-line bundle between the event logic and lora_tx.
interface lora_tx_if
  import lora_pkg::*;
#(
  parameter int unsigned NUM_BYTES = NUM_BYTES_DFLT
);

  logic                           send;
  logic [BITS_PER_BYTE*NUM_BYTES-1:0] data_in;
  logic                           data_tx;
  logic                           busy;
  logic                           done;

  modport master (output send, data_in, input data_tx, busy, done);
  modport slave  (input send, data_in, output data_tx, busy, done);

endinterface

// File: rtl/uart_byte_tx.sv
// Single UART character transmitter: start, 8 data bits LSB first,
// optional even parity (LORA_TX_PARITY_EN), stop. ready_o is high in idle
// and in the last clock of the stop bit, so a start_i there chains the next
// character with no gap.
module uart_byte_tx
  import lora_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [BITS_PER_BYTE-1:0] byte_i,
  output logic                     tx_o,
  output logic                     ready_o
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
  localparam logic [2:0]       BIT_LAST = 3'(BITS_PER_BYTE - 1);

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [2:0]               bit_q;
  logic [BITS_PER_BYTE-1:0] byte_q;
  logic                     tx_q;
  logic                     ready_q;
  logic                     wrap_c;

  assign wrap_c  = (cnt_q == CNT_LAST);
  assign tx_o    = tx_q;
  assign ready_o = ready_q;

  // Character FSM with baud counter; ready_q is precomputed one clock ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      cnt_q   <= (state_q == ST_IDLE || wrap_c) ? '0 : cnt_q + CNT_W'(1);
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_START;
            tx_q    <= 1'b0;
            byte_q  <= byte_i;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_START: begin
          if (wrap_c) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
            tx_q    <= byte_q[0];
          end
        end
        ST_DATA: begin
          if (wrap_c) begin
            if (bit_q == BIT_LAST) begin
`ifdef LORA_TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= ^byte_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= byte_q[bit_q + 3'd1];
            end
          end
        end
`ifdef LORA_TX_PARITY_EN
        ST_PARITY: begin
          if (wrap_c) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (wrap_c) begin
            if (start_i) begin
              state_q <= ST_START;
              tx_q    <= 1'b0;
              byte_q  <= byte_i;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
              ready_q <= 1'b1;
            end
          end else if (cnt_q == CNT_PRE) begin
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/lora_tx.sv
// LoRa UART frame transmitter: latches NUM_BYTES bytes on send and emits
// them MSB byte first as back-to-back UART characters.
// Build option LORA_TX_PARITY_EN selects 8E1 characters instead of 8N1.
module lora_tx
  import lora_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = BAUD_DIV_DFLT,
  parameter int unsigned NUM_BYTES = NUM_BYTES_DFLT
) (
  input  logic      clk,
  input  logic      rst_n,
  lora_tx_if.slave  bus
);

  localparam int unsigned PW       = BITS_PER_BYTE * NUM_BYTES;
  localparam logic [2:0]  LAST_IDX = 3'(NUM_BYTES - 1);

  logic                     busy_q;
  logic                     done_q;
  logic [2:0]               idx_q;
  logic [PW-1:0]            payload_q;
  logic                     start_c;
  logic [BITS_PER_BYTE-1:0] byte_c;
  logic                     tx_ready;
  logic                     tx_line;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.data_tx = tx_line;

  // Byte launch: byte 0 straight from the bus on acceptance, later bytes from the payload register.
  always_comb begin
    start_c = 1'b0;
    byte_c  = payload_q[PW-1 -: BITS_PER_BYTE];
    if (!busy_q) begin
      start_c = bus.send;
      byte_c  = bus.data_in[PW-1 -: BITS_PER_BYTE];
    end else begin
      start_c = tx_ready && (idx_q != LAST_IDX);
    end
  end

  // Frame sequencing: payload holds the bytes not yet handed to the character sender.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      payload_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (bus.send) begin
          busy_q    <= 1'b1;
          idx_q     <= '0;
          payload_q <= bus.data_in << BITS_PER_BYTE;
        end
      end else if (tx_ready) begin
        if (idx_q == LAST_IDX) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx_q     <= idx_q + 3'd1;
          payload_q <= payload_q << BITS_PER_BYTE;
        end
      end
    end
  end

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_c),
    .byte_i  (byte_c),
    .tx_o    (tx_line),
    .ready_o (tx_ready)
  );

endmodule

// File: tb/tb_lora_tx.sv
// Self-checking bench for lora_tx against a cycle-position line model.
// Honours LORA_TX_PARITY_EN to expect 8E1 characters.
module tb_lora_tx;

  localparam int BAUD = 434;
  localparam int NB   = 4;
`ifdef LORA_TX_PARITY_EN
  localparam int          CHAR_BITS = 11;
  localparam int          SPEC_LEN  = 19096;
  localparam logic [31:0] A_PL      = 32'h0701_0000;
`else
  localparam int          CHAR_BITS = 10;
  localparam int          SPEC_LEN  = 17360;
  localparam logic [31:0] A_PL      = 32'h3131_7944;
`endif
  localparam int FRAME   = NB * CHAR_BITS * BAUD;
  localparam int ABORT_K = (2 * CHAR_BITS + 4) * BAUD + BAUD / 2;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [3:0]  par_obs;
  logic [31:0] pl_c;
  bit          ab;

  lora_tx_if #(.NUM_BYTES(NB)) bus ();

  lora_tx #(
    .BAUD_DIV  (BAUD),
    .NUM_BYTES (NB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected line level k cycles after the start bit of a frame carrying pl.
  function automatic logic exp_line(input logic [31:0] pl, input int k);
    int slot;
    int ch;
    int pos;
    logic [7:0] b;
    slot = k / BAUD;
    ch   = slot / CHAR_BITS;
    pos  = slot % CHAR_BITS;
    b    = pl[8*(NB-1-ch) +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[3'(pos-1)];
`ifdef LORA_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Follows one frame from the cycle after acceptance until done (or an abort).
  task automatic watch_frame(input logic [31:0] pl, input int ign_k, input int abort_k,
                             input bit chain, input logic [31:0] next_pl, output bit aborted);
    int  k;
    int  first_low;
    int  ign2;
    bit  seen_done;
    first_low = -1;
    seen_done = 1'b0;
    aborted   = 1'b0;
    ign2      = (ign_k >= 0) ? int'($urandom_range(1, FRAME - 2)) : -1;
    for (k = 0; k < FRAME + 16; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen_done = 1'b1;
        break;
      end
      if (first_low < 0 && bus.data_tx == 1'b0) first_low = k;
      if (k < FRAME) begin
        check("line", 32'(bus.data_tx), 32'(exp_line(pl, k)));
        check("busy", 32'(bus.busy), 32'd1);
`ifdef LORA_TX_PARITY_EN
        if (k % BAUD == BAUD / 2 && (k / BAUD) % CHAR_BITS == 9)
          par_obs[2'(3 - k / (BAUD * CHAR_BITS))] = bus.data_tx;
`endif
      end
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_line", 32'(bus.data_tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("rst_hold_line", 32'(bus.data_tx), 32'd1);
        check("rst_hold_done", 32'(bus.done), 32'd0);
        rst_n       = 1'b1;
        bus.send    = 1'b1;
        bus.data_in = next_pl;
        aborted     = 1'b1;
        return;
      end
      if (k == ign_k || k == ign2) begin
        bus.send    = 1'b1;
        bus.data_in = 32'hFFFF_FFFF;
      end else begin
        bus.send    = 1'b0;
        bus.data_in = $urandom();
      end
    end
    check("start_lat", 32'(first_low), 32'd0);
    check("frame_len", 32'(k - first_low), 32'(SPEC_LEN));
    check("done_seen", 32'(seen_done), 32'd1);
    if (seen_done) begin
      check("done_busy", 32'(bus.busy), 32'd0);
      check("done_line", 32'(bus.data_tx), 32'd1);
    end
    bus.send    = chain;
    bus.data_in = next_pl;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.send = 1'b0;
      check("idle_line", 32'(bus.data_tx), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    par_obs     = '0;
    rst_n       = 1'b0;
    bus.send    = 1'b1;
    bus.data_in = $urandom();

    // Reset held with send asserted: nothing may leave the transmitter.
    #15;
    check("reset_line", 32'(bus.data_tx), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    bus.send = 1'b0;
    idle_check(3 + int'($urandom_range(0, 4)));

    // Frame A, then frame B requested in A's done cycle; B carries ignored sends.
    bus.send    = 1'b1;
    bus.data_in = A_PL;
    watch_frame(A_PL, -1, -1, 1'b1, 32'h0000_0000, ab);
`ifdef LORA_TX_PARITY_EN
    check("parity_bits", 32'(par_obs), 32'(4'b1100));
`endif
    watch_frame(32'h0000_0000, 5000, -1, 1'b0, 32'h0, ab);
    idle_check(5);

    // Random frame cut by reset during byte 2 bit 3, then a fresh frame at release.
    pl_c        = $urandom() & ~32'h0000_0800;
    bus.send    = 1'b1;
    bus.data_in = pl_c;
    watch_frame(pl_c, -1, ABORT_K, 1'b0, 32'hA5A5_A5A5, ab);
    check("aborted", 32'(ab), 32'd1);
    watch_frame(32'hA5A5_A5A5, -1, -1, 1'b0, 32'h0, ab);
    idle_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
